itch_payload_router: RTL and testbench

- Parametrised successor to the fixed two-way A/X dispatcher.
- Routes ITCH payloads from the parser front-end to NUM_CH per-message-type output channels. Each channel is selected by a configurable type-code map and has its own FIFO with a valid/ready handshake.
- Applies backpressure to the input instead of dropping matched messages.
- Consumes messages with unmapped types and counts them.

---
 rtl/itch_payload_router.sv | 94 +++++++++
 tb/tb_itch_payload_router.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_payload_router.sv
// ITCH payload router: maps each message type byte to one of NUM_CH output channels.
// Every channel has its own small FIFO; unmapped types are consumed and counted.
module itch_payload_router #(
  parameter int                  PAYLOAD_WIDTH = 512,
  parameter int                  NUM_CH        = 4,
  parameter int                  FIFO_DEPTH    = 4,
  parameter logic [NUM_CH*8-1:0] TYPE_MAP      = 32'h44_45_58_41,
  parameter int                  CNT_WIDTH     = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [7:0]                                    msg_type,
  input  logic [PAYLOAD_WIDTH-1:0]                      payload,
  output logic [NUM_CH-1:0]                             out_valid,
  input  logic [NUM_CH-1:0]                             out_ready,
  output logic [NUM_CH*PAYLOAD_WIDTH-1:0]               out_payload,
  output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]      ch_level,
  output logic [CNT_WIDTH-1:0]                          unknown_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [PAYLOAD_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr [NUM_CH];
  logic [AW-1:0]            rd_ptr [NUM_CH];
  logic [LW-1:0]            level  [NUM_CH];

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              matched;
  logic              accept;

  // Lowest-index match wins when the map contains duplicate codes.
  always_comb begin
    sel     = '0;
    matched = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!matched && (msg_type == TYPE_MAP[8*i +: 8])) begin
        sel[i]  = 1'b1;
        matched = 1'b1;
      end
    end
  end

  assign in_ready = !rst && (!matched || ((sel & full) == '0));
  assign accept   = in_valid && in_ready;
  assign push     = accept ? sel : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign full[g]                                  = (level[g] == LW'(FIFO_DEPTH));
    assign out_valid[g]                             = (level[g] != '0);
    assign pop[g]                                   = out_valid[g] && out_ready[g];
    assign out_payload[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = out_valid[g] ? mem[g][rd_ptr[g]] : '0;
    assign ch_level[g*LW +: LW]                     = level[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        level[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (push[i] && !pop[i])      level[i] <= level[i] + LW'(1);
        else if (pop[i] && !push[i]) level[i] <= level[i] - LW'(1);
      end
    end
  end

  // Storage is not reset; a slot is only ever read after a push has filled it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unknown_cnt <= '0;
    end else if (accept && !matched && (unknown_cnt != '1)) begin
      unknown_cnt <= unknown_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_itch_payload_router.sv
// Randomized scoreboard bench for itch_payload_router with a per-channel queue model.
module tb_itch_payload_router;

  localparam int PW    = 512;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int CW    = 16;

  typedef logic [PW-1:0] pl_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          msg_type;
  logic [PW-1:0]       payload;
  logic [NCH-1:0]      out_valid;
  logic [NCH-1:0]      out_ready;
  logic [NCH*PW-1:0]   out_payload;
  logic [NCH*LW-1:0]   ch_level;
  logic [CW-1:0]       unknown_cnt;

  itch_payload_router #(
    .PAYLOAD_WIDTH(PW),
    .NUM_CH(NCH),
    .FIFO_DEPTH(DEPTH),
    .TYPE_MAP(32'h44_45_58_41),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .msg_type(msg_type),
    .payload(payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_payload(out_payload),
    .ch_level(ch_level),
    .unknown_cnt(unknown_cnt)
  );

  always #5 clk = ~clk;

  pl_t q [NCH][$];
  int  lvl_snap [NCH];
  int  unk_model;
  bit  mon_en;
  bit  rnd_rdy;
  int  checks;
  int  failures;

  // Channel assignment straight from the message letters: A->0, X->1, E->2, D->3.
  function automatic int chan_of(input logic [7:0] t);
    case (t)
      8'h41:   return 0;
      8'h58:   return 1;
      8'h45:   return 2;
      8'h44:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic pl_t rand_pl();
    pl_t r;
    for (int i = 0; i < PW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares every channel head/level against the model and retires popped entries.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = q[c].size();
        lvl_snap[c] = n;
        chk($sformatf("level_ch%0d", c), PW'(ch_level[c*LW +: LW]), PW'(n));
        chk($sformatf("valid_ch%0d", c), PW'(out_valid[c]), PW'(n != 0));
        if (n == 0) chk($sformatf("idle_payload_ch%0d", c), out_payload[c*PW +: PW], '0);
        else        chk($sformatf("head_ch%0d", c), out_payload[c*PW +: PW], q[c][0]);
        if (out_valid[c] && out_ready[c] && n > 0) void'(q[c].pop_front());
      end
      chk("unknown_cnt", PW'(unknown_cnt), PW'(unk_model));
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = NCH'($urandom);
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one message and records the expected outcome once the DUT takes it.
  task automatic send(input logic [7:0] t, input pl_t p);
    int ch;
    bit exp_rdy;
    bit done;
    int waited;
    ch       = chan_of(t);
    in_valid = 1'b1;
    msg_type = t;
    payload  = p;
    done     = 1'b0;
    waited   = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      exp_rdy = (ch < 0) || (lvl_snap[ch] < DEPTH);
      chk("in_ready", PW'(in_ready), PW'(exp_rdy));
      if (in_ready) begin
        done = 1'b1;
        if (ch >= 0) q[ch].push_back(p);
        else         unk_model = (unk_model + 1 > 65535) ? 65535 : unk_model + 1;
      end else begin
        waited++;
        if (waited > 50) begin
          chk("accept_timeout", PW'(0), PW'(1));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("in_ready_in_rst", PW'(in_ready), PW'(0));
    for (int c = 0; c < NCH; c++) q[c].delete();
    unk_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    unk_model = 0;
    mon_en    = 1'b0;
    rnd_rdy   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    msg_type  = 8'h00;
    payload   = '0;
    out_ready = 4'b1111;
    do_reset();
    mon_en = 1'b1;

    // Single A, one-cycle latency, popped immediately.
    send(8'h41, PW'(32'h1234));
    idle(3);

    // Fill ch1 behind a stalled consumer, cross-channel traffic, then release.
    out_ready = 4'b1101;
    for (int p = 1; p <= 4; p++) send(8'h58, PW'(p));
    send(8'h41, PW'(32'hA0));
    fork
      send(8'h58, PW'(5));
      begin
        repeat (3) @(posedge clk);
        #2;
        out_ready[1] = 1'b1;
      end
    join
    idle(8);

    // Unmapped types are consumed and counted.
    for (int k = 0; k < 3; k++) send(8'h5A, rand_pl());
    idle(2);

    // Continuous E stream with an always-ready consumer.
    out_ready = 4'b1111;
    for (int k = 0; k < 20; k++) send(8'h45, PW'(k + 100));
    idle(3);

    // Reset in the middle of buffered traffic.
    out_ready = 4'b1110;
    for (int k = 0; k < 3; k++) send(8'h41, rand_pl());
    send(8'h5A, rand_pl());
    idle(1);
    do_reset();
    out_ready = 4'b1111;
    send(8'h41, PW'(32'hAB));
    idle(3);

    // Randomized mix with random consumer readiness.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        case ($urandom_range(0, 5))
          0:       send(8'h41, rand_pl());
          1:       send(8'h58, rand_pl());
          2:       send(8'h45, rand_pl());
          3:       send(8'h44, rand_pl());
          4:       send(8'h5A, rand_pl());
          default: send(8'($urandom), rand_pl());
        endcase
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 4'b1111;
    idle(10);

    // Counter saturation.
    do_reset();
    for (int k = 0; k < 65537; k++) send(8'h5A, '0);
    idle(2);

    out_ready = 4'b1111;
    idle(10);
    for (int c = 0; c < NCH; c++) chk($sformatf("drained_ch%0d", c), PW'(ch_level[c*LW +: LW]), PW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
